ps2_mouse_cmd_seq: RTL

Controller that sequences the PS/2 mouse bring-up and then frames the mouse's streaming bytes into movement packets. It sits between the PS/2 byte transmitter/receiver (the low-level frame engine) and user logic such as cursor or LED debug. It issues the command script to the frame engine, checks every response, and handles timeouts and retries. After init it assembles 3-byte packets, or 4-byte packets in wheel mode.

---
 rtl/ps2_mouse_cmd_seq_if.sv | 29 ++
 rtl/ps2_mouse_cmd_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_cmd_seq_if.sv
// ps2_mouse_cmd_seq_if
//   Link between the mouse command sequencer and the PS/2 frame engine.
//   master : sequencer side (drives tx_data/tx_req, observes engine status and rx bytes)
//   slave  : frame engine side
//   Signals:
//     tx_data  [7:0] command byte to transmit, valid with tx_req
//     tx_req         one-cycle transmit request
//     tx_busy        engine is transmitting
//     tx_done        one-cycle pulse, host-to-device frame finished
//     rx_data  [7:0] byte received from the mouse
//     rx_valid       one-cycle pulse, rx_data valid
interface ps2_mouse_cmd_seq_if;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_busy;
    logic       tx_done;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        output tx_data, tx_req,
        input  tx_busy, tx_done, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_req,
        output tx_busy, tx_done, rx_data, rx_valid
    );
endinterface

// File: rtl/ps2_mouse_cmd_seq.sv
// ps2_mouse_cmd_seq
//   Runs the PS/2 mouse bring-up script through the frame engine (with ack
//   checking, timeouts and bounded retries), then frames streaming bytes into
//   movement packets.
//   Optional build macro: PS2_WHEEL_EN (IntelliMouse wheel detection, 4-byte packets).
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     start        one-cycle pulse; begins/restarts the script (IDLE, STREAM, ERROR)
//     ps2          frame engine link (master modport)
//     init_done    high while streaming
//     init_error   high while in the sticky error state
//     pkt_valid    one-cycle pulse, packet outputs updated
//     pkt_buttons  {middle,right,left}
//     pkt_dx/dy    9-bit two's-complement deltas
//     pkt_ovf      {Y ovf, X ovf}
//     pkt_dz       wheel delta (0 unless wheel mode)
//     debug_state  {retry_cnt[1:0], cmd_idx[2:0], state[2:0]}
module ps2_mouse_cmd_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter logic [7:0]  SAMPLE_RATE    = 8'd100
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    ps2_mouse_cmd_seq_if.master        ps2,
    output logic                       init_done,
    output logic                       init_error,
    output logic                       pkt_valid,
    output logic [2:0]                 pkt_buttons,
    output logic [8:0]                 pkt_dx,
    output logic [8:0]                 pkt_dy,
    output logic [1:0]                 pkt_ovf,
    output logic [3:0]                 pkt_dz,
    output logic [7:0]                 debug_state
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RW = (MAX_RETRY < 4) ? 2 : $clog2(MAX_RETRY + 1);

`ifdef PS2_WHEEL_EN
    localparam int unsigned     CW        = 4;
    localparam logic [CW-1:0]   LAST_IDX  = 4'd11;
    localparam logic [CW-1:0]   GETID_IDX = 4'd10;
`else
    localparam int unsigned     CW        = 3;
    localparam logic [CW-1:0]   LAST_IDX  = 3'd3;
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND     = 3'd1,
        WAIT_TX  = 3'd2,
        WAIT_ACK = 3'd3,
        WAIT_BAT = 3'd4,
        WAIT_ID  = 3'd5,
        STREAM   = 3'd6,
        ERROR    = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] tmo_q;
    logic          tmo_expired, tmo_run, in_wait;
    logic          tx_req_c, fail, advance, restart;
    logic [7:0]    cmd_byte;

    logic [1:0]    byte_cnt;
    logic [1:0]    last_cnt;
    logic [6:0]    hdr_q;     // byte0 without the always-one bit 3
    logic [7:0]    b1_q, b2_q;
    logic          gap_expired;

`ifdef PS2_WHEEL_EN
    logic          wheel_q, wheel_set;
    assign last_cnt = wheel_q ? 2'd3 : 2'd2;
`else
    assign last_cnt = 2'd2;
    assign pkt_dz   = '0;
`endif

    // Command script ROM
    always_comb begin
        cmd_byte = 8'h00;
        case (idx_q)
            CW'(0):  cmd_byte = 8'hFF;
            CW'(1):  cmd_byte = 8'hF3;
            CW'(2):  cmd_byte = SAMPLE_RATE;
            CW'(3):  cmd_byte = 8'hF4;
`ifdef PS2_WHEEL_EN
            CW'(4):  cmd_byte = 8'hF3;
            CW'(5):  cmd_byte = 8'hC8;
            CW'(6):  cmd_byte = 8'hF3;
            CW'(7):  cmd_byte = 8'h64;
            CW'(8):  cmd_byte = 8'hF3;
            CW'(9):  cmd_byte = 8'h50;
            CW'(10): cmd_byte = 8'hF2;
            CW'(11): cmd_byte = 8'hF4;
`endif
            default: cmd_byte = 8'h00;
        endcase
    end

    assign in_wait     = state_q inside {WAIT_TX, WAIT_ACK, WAIT_BAT, WAIT_ID};
    assign tmo_expired = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign gap_expired = (state_q == STREAM) && (byte_cnt != 2'd0) && tmo_expired;

    // Next-state logic. cmd_idx only advances once a command is fully
    // answered: FF stays at index 0 through BAT and ID, so any failure there
    // retries FF, and retry_cnt clears only on completion (not on the bare
    // FF ack), which keeps a mouse that acks but never sends BAT bounded.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        retry_d  = retry_q;
        tx_req_c = 1'b0;
        fail     = 1'b0;
        advance  = 1'b0;
        restart  = 1'b0;
`ifdef PS2_WHEEL_EN
        wheel_set = 1'b0;
`endif
        case (state_q)
            IDLE, STREAM, ERROR: begin
                if (start) restart = 1'b1;
            end
            SEND: begin
                if (!ps2.tx_busy) begin
                    tx_req_c = 1'b1;
                    state_d  = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (ps2.tx_done)      state_d = WAIT_ACK;
                else if (tmo_expired) fail    = 1'b1;
            end
            WAIT_ACK: begin
                if (ps2.rx_valid) begin
                    if (ps2.rx_data != 8'hFA)   fail    = 1'b1;
                    else if (idx_q == '0)       state_d = WAIT_BAT;
`ifdef PS2_WHEEL_EN
                    else if (idx_q == GETID_IDX) state_d = WAIT_ID;
`endif
                    else                        advance = 1'b1;
                end else if (tmo_expired) begin
                    fail = 1'b1;
                end
            end
            WAIT_BAT: begin
                if (ps2.rx_valid) begin
                    if (ps2.rx_data == 8'hAA) state_d = WAIT_ID;
                    else                      fail    = 1'b1;
                end else if (tmo_expired) begin
                    fail = 1'b1;
                end
            end
            WAIT_ID: begin
                if (ps2.rx_valid) begin
`ifdef PS2_WHEEL_EN
                    if (idx_q == GETID_IDX) begin
                        advance   = 1'b1;
                        wheel_set = (ps2.rx_data == 8'h03);
                    end else
`endif
                    if (ps2.rx_data == 8'h00) advance = 1'b1;
                    else                      fail    = 1'b1;
                end else if (tmo_expired) begin
                    fail = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (restart) begin
            state_d = SEND;
            idx_d   = '0;
            retry_d = '0;
        end
        if (advance) begin
            retry_d = '0;
            if (idx_q == LAST_IDX) begin
                state_d = STREAM;
            end else begin
                idx_d   = idx_q + CW'(1);
                state_d = SEND;
            end
        end
        if (fail) begin
            if (retry_q < RW'(MAX_RETRY)) begin
                retry_d = retry_q + RW'(1);
                state_d = SEND;
            end else begin
                state_d = ERROR;
            end
        end
    end

    // Counter restarts on every state entry; in STREAM it measures the gap
    // since the last byte of a partially received packet.
    assign tmo_run = (in_wait && (state_d == state_q)) ||
                     ((state_q == STREAM) && (state_d == STREAM) &&
                      (byte_cnt != 2'd0) && !ps2.rx_valid && !tmo_expired);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            retry_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            tmo_q   <= tmo_run ? tmo_q + TW'(1) : '0;
        end
    end

`ifdef PS2_WHEEL_EN
    always_ff @(posedge clk) begin
        if (rst || restart) wheel_q <= 1'b0;
        else if (wheel_set) wheel_q <= 1'b1;
    end
`endif

    // Packet assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt    <= '0;
            hdr_q       <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            pkt_valid   <= 1'b0;
            pkt_buttons <= '0;
            pkt_dx      <= '0;
            pkt_dy      <= '0;
            pkt_ovf     <= '0;
`ifdef PS2_WHEEL_EN
            pkt_dz      <= '0;
`endif
        end else begin
            pkt_valid <= 1'b0;
            if (state_q != STREAM) begin
                byte_cnt <= '0;
            end else if (ps2.rx_valid) begin
                if (byte_cnt == 2'd0) begin
                    // Header bit 3 is always set; anything else is out of sync.
                    if (ps2.rx_data[3]) begin
                        hdr_q    <= {ps2.rx_data[7:4], ps2.rx_data[2:0]};
                        byte_cnt <= 2'd1;
                    end
                end else if (byte_cnt == last_cnt) begin
                    pkt_buttons <= hdr_q[2:0];
                    pkt_dx      <= {hdr_q[3], b1_q};
                    pkt_dy      <= {hdr_q[4], (byte_cnt == 2'd2) ? ps2.rx_data : b2_q};
                    pkt_ovf     <= hdr_q[6:5];
`ifdef PS2_WHEEL_EN
                    pkt_dz      <= wheel_q ? ps2.rx_data[3:0] : 4'h0;
`endif
                    pkt_valid   <= 1'b1;
                    byte_cnt    <= 2'd0;
                end else begin
                    if (byte_cnt == 2'd1) b1_q <= ps2.rx_data;
                    else                  b2_q <= ps2.rx_data;
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end else if (gap_expired) begin
                byte_cnt <= 2'd0;
            end
        end
    end

    assign ps2.tx_req  = tx_req_c;
    assign ps2.tx_data = tx_req_c ? cmd_byte : 8'h00;
    assign init_done   = (state_q == STREAM);
    assign init_error  = (state_q == ERROR);
    assign debug_state = {retry_q[1:0], idx_q[2:0], state_q};

endmodule
